// File: rtl/fpu_sched.sv
// -----------------------------------------------------------------------------
// fpu_sched
//
// Sequencing controller between the floating-point decode FSM and the FPU
// function units. It accepts one issue pulse, decodes funct7 to a target unit,
// pulses that unit's start bit, and then either counts out the unit's fixed
// latency or waits for its done strobe, bounded by a timeout. The captured
// result is returned with a single fpu_valid pulse. One operation in flight.
//
// Ports
//   clk        in   1    rising-edge clock
//   rstn       in   1    asynchronous active-low reset
//   fpu_go     in   1    issue pulse, sampled only in IDLE
//   funct7     in   7    operation select
//   funct3     in   3    compare/sign sub-function
//   x, y       in   32   operands
//   unit_res   in   224  7x32 unit results, unit k at [32k+31:32k]
//   unit_done  in   7    done strobes (div = bit 2, sqrt = bit 3)
//   unit_start out  7    one-hot start pulse
//   op_a, op_b out  32   registered operands
//   op_f3      out  3    registered funct3
//   op_sub     out  1    1 for fsub
//   fpu_valid  out  1    one-cycle result pulse
//   fpu_res    out  32   result, held until the next fpu_valid
//   fregwb     out  1    1 for an integer-register destination
//   fpu_busy   out  1    high in every state except IDLE
//   fpu_err    out  1    pulse with fpu_valid on illegal op or timeout
// -----------------------------------------------------------------------------
module fpu_sched #(
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 2,
  parameter int CMP_LAT = 1,
  parameter int CVT_LAT = 2,
  parameter int TIMEOUT = 63
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         fpu_go,
  input  logic [6:0]   funct7,
  input  logic [2:0]   funct3,
  input  logic [31:0]  x,
  input  logic [31:0]  y,
  input  logic [223:0] unit_res,
  input  logic [6:0]   unit_done,
  output logic [6:0]   unit_start,
  output logic [31:0]  op_a,
  output logic [31:0]  op_b,
  output logic [2:0]   op_f3,
  output logic         op_sub,
  output logic         fpu_valid,
  output logic [31:0]  fpu_res,
  output logic         fregwb,
  output logic         fpu_busy,
  output logic         fpu_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_COUNT,
    S_WAIT_DONE,
    S_RESP
  } state_e;

  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

  state_e       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [2:0]   unit_q, unit_d;
  logic         legal_q, legal_d;
  logic         wb_lat_q, wb_lat_d;   // fregwb of the op in flight
  logic [6:0]   unit_start_q, unit_start_d;
  logic [31:0]  op_a_q, op_a_d;
  logic [31:0]  op_b_q, op_b_d;
  logic [2:0]   op_f3_q, op_f3_d;
  logic         op_sub_q, op_sub_d;
  logic         valid_q, valid_d;
  logic [31:0]  res_q, res_d;
  logic         fregwb_q, fregwb_d;
  logic         busy_q, busy_d;
  logic         err_q, err_d;

  // Decode of the incoming funct7.
  logic [2:0] dec_unit;
  logic       dec_legal;
  logic       dec_wb;

  always_comb begin
    dec_unit  = 3'd0;
    dec_legal = 1'b1;
    dec_wb    = 1'b0;
    unique case (funct7)
      7'b0000000, 7'b0000100: dec_unit = 3'd0;
      7'b0001000:             dec_unit = 3'd1;
      7'b0001100:             dec_unit = 3'd2;
      7'b0101100:             dec_unit = 3'd3;
      7'b1010000: begin       dec_unit = 3'd4; dec_wb = 1'b1; end
      7'b1100000: begin       dec_unit = 3'd5; dec_wb = 1'b1; end
      7'b1101000:             dec_unit = 3'd6;
      default:                dec_legal = 1'b0;
    endcase
  end

  // Fixed latency of the latched unit (only meaningful for non div/sqrt).
  logic [7:0] unit_lat;
  always_comb begin
    unit_lat = 8'(ADD_LAT);
    case (unit_q)
      3'd1:       unit_lat = 8'(MUL_LAT);
      3'd4:       unit_lat = 8'(CMP_LAT);
      3'd5, 3'd6: unit_lat = 8'(CVT_LAT);
      default:    unit_lat = 8'(ADD_LAT);
    endcase
  end

  logic [31:0] sel_res;
  assign sel_res = unit_res[{unit_q, 5'b0} +: 32];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    state_d      = state_q;
    cnt_d        = cnt_q;
    unit_d       = unit_q;
    legal_d      = legal_q;
    wb_lat_d     = wb_lat_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_f3_d      = op_f3_q;
    op_sub_d     = op_sub_q;
    res_d        = res_q;
    fregwb_d     = fregwb_q;
    unit_start_d = '0;
    valid_d      = 1'b0;
    err_d        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (fpu_go) begin
          op_a_d   = x;
          op_b_d   = y;
          op_f3_d  = funct3;
          op_sub_d = (funct7 == 7'b0000100);
          unit_d   = dec_unit;
          legal_d  = dec_legal;
          wb_lat_d = dec_wb;
          // Start is registered, so it is set on the edge entering ISSUE.
          if (dec_legal) unit_start_d = 7'(7'b1 << dec_unit);
          state_d  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (!legal_q) begin
          res_d    = '0;
          valid_d  = 1'b1;
          err_d    = 1'b1;
          fregwb_d = wb_lat_q;
          state_d  = S_RESP;
        end else if (unit_q == 3'd2 || unit_q == 3'd3) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else begin
          cnt_d   = unit_lat;
          state_d = S_COUNT;
        end
      end

      S_COUNT: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          res_d    = sel_res;
          valid_d  = 1'b1;
          fregwb_d = wb_lat_q;
          state_d  = S_RESP;
        end
      end

      S_WAIT_DONE: begin
        cnt_d = cnt_q + 8'd1;
        // Done is tested first so it wins over a simultaneous timeout.
        if (unit_done[unit_q]) begin
          res_d    = sel_res;
          valid_d  = 1'b1;
          fregwb_d = wb_lat_q;
          state_d  = S_RESP;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          res_d    = CANON_NAN;
          valid_d  = 1'b1;
          err_d    = 1'b1;
          fregwb_d = wb_lat_q;
          state_d  = S_RESP;
        end
      end

      S_RESP: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      unit_q       <= '0;
      legal_q      <= 1'b0;
      wb_lat_q     <= 1'b0;
      unit_start_q <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_f3_q      <= '0;
      op_sub_q     <= 1'b0;
      valid_q      <= 1'b0;
      res_q        <= '0;
      fregwb_q     <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      unit_q       <= unit_d;
      legal_q      <= legal_d;
      wb_lat_q     <= wb_lat_d;
      unit_start_q <= unit_start_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_f3_q      <= op_f3_d;
      op_sub_q     <= op_sub_d;
      valid_q      <= valid_d;
      res_q        <= res_d;
      fregwb_q     <= fregwb_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign unit_start = unit_start_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign op_f3      = op_f3_q;
  assign op_sub     = op_sub_q;
  assign fpu_valid  = valid_q;
  assign fpu_res    = res_q;
  assign fregwb     = fregwb_q;
  assign fpu_busy   = busy_q;
  assign fpu_err    = err_q;

endmodule

// File: doc/fpu_sched.md
# fpu_sched

Sequencing controller between the floating-point decode FSM and the FPU function units. It accepts a one-cycle `fpu_go` issue pulse together with `funct7`/`funct3` and the operands, and selects the target unit. It starts that unit and counts out a fixed latency or waits for a done handshake, depending on the unit. It then returns one `fpu_valid` pulse with the captured result and the `fregwb` flag, which is 1 for an integer-register destination. One operation is in flight at a time.

## Interface
Parameters:
- `ADD_LAT` = 2: fixed cycles for the add/sub unit (≥1).
- `MUL_LAT` = 2: fixed cycles for fmul (≥1).
- `CMP_LAT` = 1: fixed cycles for the compare unit (≥1).
- `CVT_LAT` = 2: fixed cycles for both convert units (≥1).
- `TIMEOUT` = 63: maximum WAIT_DONE cycles for div/sqrt (≥1, ≤255).

Ports (clk and rstn first):
- `clk  in  1`: single clock, rising edge.
- `rstn  in  1`: reset, asynchronous, active-low.
- `fpu_go  in  1`: issue pulse, sampled only in IDLE.
- `funct7  in  7`: operation select.
- `funct3  in  3`: compare/sign sub-function.
- `x, y  in  32`: operands.
- `unit_res  in  224`: 7×32 unit results; unit k occupies bits [32k+31:32k].
- `unit_done  in  7`: done strobes; only bits 2 (div) and 3 (sqrt) are used.
- `unit_start  out  7`: one-hot start pulse.
- `op_a, op_b  out  32`: registered operands to the units.
- `op_f3  out  3`: registered funct3.
- `op_sub  out  1`: 1 for fsub.
- `fpu_valid  out  1`: one-cycle result pulse.
- `fpu_res  out  32`: result; holds until the next `fpu_valid`.
- `fregwb  out  1`: 1 when the destination is an integer register; valid with `fpu_valid`, then held.
- `fpu_busy  out  1`: high in every state except IDLE.
- `fpu_err  out  1`: one-cycle pulse coincident with `fpu_valid` on an illegal op or timeout.

## Operation
- Unit decode (funct7 → unit k, fregwb):
  - 0000000 / 0000100 (fadd/fsub) → 0, fregwb 0.
  - 0001000 (fmul) → 1, fregwb 0.
  - 0001100 (fdiv) → 2, fregwb 0.
  - 0101100 (fsqrt) → 3, fregwb 0.
  - 1010000 (feq/flt/fle) → 4, fregwb 1.
  - 1100000 (fcvt.w.s) → 5, fregwb 1.
  - 1101000 (fcvt.s.w) → 6, fregwb 0.
  - Any other value → illegal.
- States: IDLE, ISSUE, COUNT, WAIT_DONE, RESP.
- IDLE: when `fpu_go`=1, latch x→op_a, y→op_b, funct3→op_f3, the unit index, fregwb and op_sub, then go to ISSUE. When `fpu_go`=0, stay in IDLE.
- ISSUE: drive `unit_start[k]`=1 for exactly this cycle.
  - Units 2 and 3 go to WAIT_DONE.
  - All other legal units go to COUNT with the counter loaded to LAT.
  - An illegal op asserts no start bit, forces the result to 0, sets the error flag, and goes to RESP.
- COUNT: decrement the counter each cycle. On the cycle the counter equals 1, capture `unit_res[k]` and go to RESP.
- WAIT_DONE: increment the timeout counter each cycle.
  - If `unit_done[k]`=1, capture `unit_res[k]` that cycle and go to RESP. Done wins over timeout when both occur in the same cycle.
  - If the counter reaches TIMEOUT with no done, capture 0x7FC00000, set the error flag, and go to RESP.
  - Done strobes on non-selected units are ignored.
- RESP: `fpu_valid`=1; `fpu_err` = error flag; go to IDLE.
- `fpu_go` outside IDLE is ignored: no queueing, no error.
- Outputs `op_a`, `op_b`, `op_f3` and `op_sub` hold their values from the last issue until the next one.

## Timing
- Reset values (async on `rstn`=0, from any state):
  - State IDLE.
  - All counters 0.
  - `unit_start`=0, `fpu_valid`=0, `fpu_err`=0, `fpu_busy`=0, `fregwb`=0.
  - `fpu_res`=0, `op_a`=0, `op_b`=0, `op_f3`=0, `op_sub`=0.
  - A reset mid-operation discards the operation with no `fpu_valid`; late `unit_done` strobes after reset are ignored.
- All outputs are registered.
- Latency for a go in cycle 0:
  - ISSUE and `unit_start` in cycle 1.
  - Fixed-latency unit with latency L: capture in cycle L+1, `fpu_valid` in cycle L+2.
  - Div/sqrt with done in cycle D (D≥2): `fpu_valid` in cycle D+1.
  - Illegal op: `fpu_valid` in cycle 2.
  - Timeout: the TIMEOUT-th WAIT_DONE cycle is cycle TIMEOUT+1; `fpu_valid` in cycle TIMEOUT+2.
- `fpu_busy` is 1 from cycle 1 through the RESP cycle inclusive.
- Back-to-back issue: a new `fpu_go` may be accepted in the cycle after RESP, so the minimum issue spacing is L+3 cycles.

## Test plan
- fadd x=0x3F800000, y=0x40000000, ADD_LAT=2, unit 0 returning 0x40400000, go in cycle 0 → `unit_start`=0000001 in cycle 1; `fpu_valid`=1 in cycle 4 with `fpu_res`=0x40400000, `fregwb`=0, `fpu_err`=0, `op_sub`=0.
- flt (funct7=1010000, funct3=001), unit 4 returning 1 → `fpu_valid` in cycle 3, `fpu_res`=1, `fregwb`=1, `op_f3`=001.
- fdiv with `unit_done[2]` in cycle 9 and result 0x3F000000 → `fpu_valid` in cycle 10 with `fpu_res`=0x3F000000; `unit_done[3]` pulsed in cycle 5 has no effect.
- fsqrt with no done, TIMEOUT=63 → `fpu_valid` and `fpu_err` in cycle 65, `fpu_res`=0x7FC00000; `fpu_busy`=1 over cycles 1–65.
- funct7=1111111 → no `unit_start` bit; `fpu_valid` and `fpu_err` in cycle 2, `fpu_res`=0. A second `fpu_go` in cycle 1 is ignored, and a go in cycle 3 is accepted.
- fmul in flight, `rstn` dropped in cycle 2 → all outputs 0 immediately; no `fpu_valid` afterwards; a fresh fmul after reset release completes in L+2 cycles.
